// File: rtl/photo_reader_emu.sv
// PL6 photoelectric tape reader emulator: host-loaded frame buffer replayed at
// tick-paced frame rates, with tape position tracked in both directions.
module photo_reader_emu #(
   parameter int DEPTH     = 4096,
   parameter int FRAME_MS  = 4,
   parameter int HOLD_MS   = 2,
   parameter int START_MS  = 20,
   parameter int REWIND_MS = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic          CLOCK,
   input  logic          rst_n,
   input  logic          tick_ms,
   input  logic          PHOTO_TAPE_FWD,
   input  logic          PHOTO_TAPE_REV,
   input  logic          REMOTE_REWIND,
   output logic          PHOTO1,
   output logic          PHOTO2,
   output logic          PHOTO3,
   output logic          PHOTO4,
   output logic          PHOTO5,
   output logic          WAIT_FOR_TAPE,
   input  logic          load_clear,
   input  logic          load_valid,
   input  logic [4:0]    load_data,
   output logic          load_ready,
   output logic [AW:0]   tape_len,
   output logic [AW:0]   tape_pos,
   output logic          at_end
);
   localparam int PW = $clog2(FRAME_MS);
   localparam int SW = $clog2(START_MS + 1);
   localparam int RW = $clog2(REWIND_MS + 1);

   localparam logic [PW-1:0] PHASE_LAST = PW'(FRAME_MS - 1);
   localparam logic [PW-1:0] PHASE_HOLD = PW'(HOLD_MS);
   localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
   localparam logic [SW-1:0] START_LAST = SW'(START_MS - 1);
   localparam logic [SW-1:0] START_ONE  = SW'(1);
   localparam logic [RW-1:0] REW_LAST   = RW'(REWIND_MS - 1);
   localparam logic [RW-1:0] REW_ONE    = RW'(1);
   localparam logic [AW:0]   POS_ONE    = (AW+1)'(1);
   localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);

   localparam logic [1:0] CMD_STOP = 2'd0;
   localparam logic [1:0] CMD_F    = 2'd1;
   localparam logic [1:0] CMD_R    = 2'd2;
   localparam logic [1:0] CMD_W    = 2'd3;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_RUN_F = 3'd2;
   localparam logic [2:0] S_RUN_R = 3'd3;
   localparam logic [2:0] S_RUN_W = 3'd4;
   localparam logic [2:0] S_END   = 3'd5;

   logic [4:0]    mem [DEPTH];
   logic [2:0]    state, state_n;
   logic [1:0]    cmd, run_cmd, run_cmd_n;
   logic [SW-1:0] start_cnt, start_cnt_n;
   logic [PW-1:0] phase, phase_n;
   logic [RW-1:0] rew_cnt, rew_cnt_n;
   logic [AW:0]   pos_n, len_n;
   logic [AW-1:0] rd_addr;
   logic [4:0]    photo_q;
   logic          wr_en, ready_n, show_n;

   always_comb begin
      if (REMOTE_REWIND)                        cmd = CMD_W;
      else if (PHOTO_TAPE_FWD && PHOTO_TAPE_REV) cmd = CMD_STOP;
      else if (PHOTO_TAPE_FWD)                  cmd = CMD_F;
      else if (PHOTO_TAPE_REV)                  cmd = CMD_R;
      else                                      cmd = CMD_STOP;
   end

   assign wr_en = load_valid & load_ready & ~load_clear;

   always_comb begin
      state_n     = state;
      run_cmd_n   = run_cmd;
      start_cnt_n = start_cnt;
      phase_n     = phase;
      rew_cnt_n   = rew_cnt;
      pos_n       = tape_pos;
      len_n       = tape_len;
      if (state == S_IDLE) begin
         if (load_clear) begin
            len_n = '0;
            pos_n = '0;
         end else if (wr_en) begin
            len_n = tape_len + POS_ONE;
         end
         if (cmd != CMD_STOP) begin
            state_n     = S_START;
            run_cmd_n   = cmd;
            start_cnt_n = '0;
         end
      end else if (cmd != run_cmd) begin
         // A mid-frame command change leaves tape_pos where it is.
         if (cmd == CMD_STOP) begin
            state_n = S_IDLE;
         end else begin
            state_n     = S_START;
            run_cmd_n   = cmd;
            start_cnt_n = '0;
         end
      end else if (tick_ms) begin
         case (state)
            S_START: begin
               if (start_cnt == START_LAST) begin
                  phase_n   = '0;
                  rew_cnt_n = '0;
                  case (run_cmd)
                     CMD_F:   state_n = (tape_pos == tape_len) ? S_END : S_RUN_F;
                     CMD_R:   state_n = (tape_pos == '0)       ? S_END : S_RUN_R;
                     default: state_n = (tape_pos == '0)       ? S_END : S_RUN_W;
                  endcase
               end else begin
                  start_cnt_n = start_cnt + START_ONE;
               end
            end
            S_RUN_F, S_RUN_R: begin
               if (phase == PHASE_LAST) begin
                  phase_n = '0;
                  if (state == S_RUN_F) begin
                     pos_n = tape_pos + POS_ONE;
                     if (pos_n == tape_len) state_n = S_END;
                  end else begin
                     pos_n = tape_pos - POS_ONE;
                     if (pos_n == '0) state_n = S_END;
                  end
               end else begin
                  phase_n = phase + PHASE_ONE;
               end
            end
            S_RUN_W: begin
               if (rew_cnt == REW_LAST) begin
                  rew_cnt_n = '0;
                  pos_n     = tape_pos - POS_ONE;
                  if (pos_n == '0) state_n = S_END;
               end else begin
                  rew_cnt_n = rew_cnt + REW_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Frame read is addressed from next-state position so the RAM output
   // register doubles as the photo output register.
   always_comb begin
      rd_addr = (state_n == S_RUN_R) ? AW'(pos_n - POS_ONE) : AW'(pos_n);
      show_n  = ((state_n == S_RUN_F) || (state_n == S_RUN_R)) && (phase_n < PHASE_HOLD);
      ready_n = (state_n == S_IDLE) && (len_n < DEPTH_L) && !load_clear;
   end

   always_ff @(posedge CLOCK) begin
      if (wr_en) mem[tape_len[AW-1:0]] <= load_data;
   end

   always_ff @(posedge CLOCK or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         run_cmd       <= CMD_STOP;
         start_cnt     <= '0;
         phase         <= '0;
         rew_cnt       <= '0;
         tape_pos      <= '0;
         tape_len      <= '0;
         photo_q       <= '0;
         WAIT_FOR_TAPE <= 1'b0;
         at_end        <= 1'b0;
         load_ready    <= 1'b0;
      end else begin
         state         <= state_n;
         run_cmd       <= run_cmd_n;
         start_cnt     <= start_cnt_n;
         phase         <= phase_n;
         rew_cnt       <= rew_cnt_n;
         tape_pos      <= pos_n;
         tape_len      <= len_n;
         photo_q       <= show_n ? mem[rd_addr] : '0;
         WAIT_FOR_TAPE <= (state_n != S_IDLE);
         at_end        <= (state_n == S_END);
         load_ready    <= ready_n;
      end
   end

   assign PHOTO1 = photo_q[0];
   assign PHOTO2 = photo_q[1];
   assign PHOTO3 = photo_q[2];
   assign PHOTO4 = photo_q[3];
   assign PHOTO5 = photo_q[4];

endmodule

// File: tb/tb_photo_reader_emu.sv
// Bench for photo_reader_emu: directed scenarios with random tick spacing and
// random tapes, checked against a tick-count arithmetic model of tape motion.
module tb_photo_reader_emu;
   localparam int DEPTH     = 4096;
   localparam int FRAME_MS  = 4;
   localparam int HOLD_MS   = 2;
   localparam int START_MS  = 20;
   localparam int REWIND_MS = 1;
   localparam int AW        = 12;
   localparam int D_F = 0, D_R = 1, D_W = 2;

   logic          CLOCK = 1'b0;
   logic          rst_n, tick_ms, fwd, rev, rewind;
   logic          PHOTO1, PHOTO2, PHOTO3, PHOTO4, PHOTO5, wait_ft;
   logic          load_clear, load_valid, load_ready, at_end;
   logic [4:0]    load_data, photo;
   logic [AW:0]   tape_len, tape_pos;

   int            vecs = 0;
   int            miss = 0;
   logic [4:0]    fr[$];
   int            pos, n, k;

   photo_reader_emu #(
      .DEPTH(DEPTH), .FRAME_MS(FRAME_MS), .HOLD_MS(HOLD_MS),
      .START_MS(START_MS), .REWIND_MS(REWIND_MS)
   ) dut (
      .CLOCK(CLOCK), .rst_n(rst_n), .tick_ms(tick_ms),
      .PHOTO_TAPE_FWD(fwd), .PHOTO_TAPE_REV(rev), .REMOTE_REWIND(rewind),
      .PHOTO1(PHOTO1), .PHOTO2(PHOTO2), .PHOTO3(PHOTO3), .PHOTO4(PHOTO4), .PHOTO5(PHOTO5),
      .WAIT_FOR_TAPE(wait_ft), .load_clear(load_clear), .load_valid(load_valid),
      .load_data(load_data), .load_ready(load_ready), .tape_len(tape_len),
      .tape_pos(tape_pos), .at_end(at_end)
   );

   assign photo = {PHOTO5, PHOTO4, PHOTO3, PHOTO2, PHOTO1};

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic t);
      tick_ms = t;
      @(posedge CLOCK);
      #1;
      tick_ms = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [4:0] e_ph, input logic e_wait,
                          input int e_pos, input logic e_end);
      chk({tag, ".photo"}, 32'(photo), 32'(e_ph));
      chk({tag, ".wait"},  32'(wait_ft), 32'(e_wait));
      chk({tag, ".pos"},   32'(tape_pos), e_pos);
      chk({tag, ".end"},   32'(at_end), 32'(e_end));
   endtask

   // Expected head state t ticks after a direction command, from frame arithmetic.
   task automatic model(input int dir, input int p0, input int t,
                        output logic [4:0] e_ph, output int e_pos, output logic e_end);
      int u, f, steps;
      e_ph = '0; e_pos = p0; e_end = 1'b0;
      if (t >= START_MS) begin
         u = t - START_MS;
         f = u / FRAME_MS;
         if (dir == D_F) begin
            if (f >= fr.size() - p0) begin
               e_pos = fr.size(); e_end = 1'b1;
            end else begin
               e_pos = p0 + f;
               if (u % FRAME_MS < HOLD_MS) e_ph = fr[p0 + f];
            end
         end else if (dir == D_R) begin
            if (f >= p0) begin
               e_pos = 0; e_end = 1'b1;
            end else begin
               e_pos = p0 - f;
               if (u % FRAME_MS < HOLD_MS) e_ph = fr[p0 - f - 1];
            end
         end else begin
            steps = u / REWIND_MS;
            e_pos = (steps >= p0) ? 0 : p0 - steps;
            e_end = (e_pos == 0);
         end
      end
   endtask

   task automatic run(input string tag, input int dir, input int p0, input int nticks,
                      output int end_pos);
      logic [4:0] e_ph;
      int         e_pos;
      logic       e_end;
      model(dir, p0, 0, e_ph, e_pos, e_end);
      chk_out({tag, ".t0"}, e_ph, 1'b1, e_pos, e_end);
      for (int t = 1; t <= nticks; t++) begin
         repeat ($urandom_range(0, 2)) begin
            cyc(1'b0);
            chk_out($sformatf("%s.idle%0d", tag, t - 1), e_ph, 1'b1, e_pos, e_end);
         end
         cyc(1'b1);
         model(dir, p0, t, e_ph, e_pos, e_end);
         chk_out($sformatf("%s.t%0d", tag, t), e_ph, 1'b1, e_pos, e_end);
      end
      end_pos = e_pos;
   endtask

   task automatic load(input logic [4:0] d);
      load_valid = 1'b1;
      load_data  = d;
      cyc(1'b0);
      load_valid = 1'b0;
      fr.push_back(d);
      chk("load.len", 32'(tape_len), fr.size());
   endtask

   task automatic clear_tape();
      load_clear = 1'b1;
      cyc(1'b0);
      load_clear = 1'b0;
      fr.delete();
      chk("clear.len", 32'(tape_len), 0);
      chk("clear.pos", 32'(tape_pos), 0);
      cyc(1'b0);
      chk("clear.ready", 32'(load_ready), 1);
   endtask

   initial begin
      rst_n = 1'b0; tick_ms = 1'b0; fwd = 1'b0; rev = 1'b0; rewind = 1'b0;
      load_clear = 1'b0; load_valid = 1'b0; load_data = '0;
      repeat (3) cyc(1'b0);
      chk_out("reset", 5'h00, 1'b0, 0, 1'b0);
      chk("reset.ready", 32'(load_ready), 0);
      chk("reset.len", 32'(tape_len), 0);
      rst_n = 1'b1;
      cyc(1'b0);
      chk("rel.ready", 32'(load_ready), 1);

      load(5'h01); load(5'h1F); load(5'h0A);

      fwd = 1'b1;
      cyc(1'b0);
      chk("fwd.wait1", 32'(wait_ft), 1);
      run("fwd", D_F, 0, START_MS + 3 * FRAME_MS + 2, pos);
      chk("fwd.end", 32'(at_end), 1);
      chk("fwd.pos3", 32'(tape_pos), 3);

      fwd = 1'b0; rev = 1'b1;
      cyc(1'b0);
      run("rev", D_R, 3, START_MS + 3 * FRAME_MS + 2, pos);
      chk("rev.pos0", 32'(tape_pos), 0);
      rev = 1'b0;
      cyc(1'b0);
      chk_out("rev.idle", 5'h00, 1'b0, 0, 1'b0);

      fwd = 1'b1;
      cyc(1'b0);
      run("abandon", D_F, 0, START_MS + FRAME_MS + 1, pos);
      chk("abandon.photo_pre", 32'(photo), 32'h1F);
      fwd = 1'b0;
      cyc(1'b0);
      chk_out("abandon.idle", 5'h00, 1'b0, 1, 1'b0);

      fwd = 1'b1;
      cyc(1'b0);
      run("fwd2", D_F, 1, START_MS + FRAME_MS, pos);
      chk("fwd2.pos", 32'(tape_pos), 2);
      rewind = 1'b1;
      cyc(1'b0);
      run("rew", D_W, 2, START_MS + 4, pos);
      fwd = 1'b0; rewind = 1'b0;
      cyc(1'b0);
      chk_out("rew.idle", 5'h00, 1'b0, 0, 1'b0);

      fwd = 1'b1; rev = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc(1'($urandom_range(0, 1)));
         chk_out($sformatf("both%0d", i), 5'h00, 1'b0, 0, 1'b0);
      end
      fwd = 1'b0; rev = 1'b0;
      cyc(1'b0);

      for (int trial = 0; trial < 4; trial++) begin
         clear_tape();
         n = (trial == 0) ? 0 : $urandom_range(1, 7);
         for (int i = 0; i < n; i++) load(5'($urandom));
         fwd = 1'b1;
         cyc(1'b0);
         run($sformatf("rf%0d", trial), D_F, 0, START_MS + n * FRAME_MS + 2, pos);
         fwd = 1'b0; rev = 1'b1;
         cyc(1'b0);
         run($sformatf("rr%0d", trial), D_R, n, START_MS + n * FRAME_MS + 2, pos);
         rev = 1'b0; fwd = 1'b1;
         cyc(1'b0);
         k = $urandom_range(0, START_MS + n * FRAME_MS + 1);
         run($sformatf("rp%0d", trial), D_F, 0, k, pos);
         fwd = 1'b0;
         cyc(1'b0);
         chk_out($sformatf("rp%0d.idle", trial), 5'h00, 1'b0, pos, 1'b0);
      end

      clear_tape();
      for (int i = 0; i < DEPTH; i++) begin
         load_valid = 1'b1;
         load_data  = 5'($urandom);
         fr.push_back(load_data);
         cyc(1'b0);
      end
      chk("fill.len", 32'(tape_len), DEPTH);
      chk("fill.ready", 32'(load_ready), 0);
      cyc(1'b0);
      load_valid = 1'b0;
      chk("fill.len_hold", 32'(tape_len), DEPTH);
      fwd = 1'b1;
      cyc(1'b0);
      run("fillrun", D_F, 0, START_MS + 2 * FRAME_MS + 1, pos);
      fwd = 1'b0;
      cyc(1'b0);
      chk_out("fillrun.idle", 5'h00, 1'b0, pos, 1'b0);
      clear_tape();

      load(5'h01); load(5'h1F); load(5'h0A);
      fwd = 1'b1;
      cyc(1'b0);
      run("prerst", D_F, 0, START_MS + FRAME_MS, pos);
      chk("prerst.photo", 32'(photo), 32'h1F);
      #2 rst_n = 1'b0;
      #1;
      chk_out("midrst", 5'h00, 1'b0, 0, 1'b0);
      chk("midrst.len", 32'(tape_len), 0);
      chk("midrst.ready", 32'(load_ready), 0);
      fwd = 1'b0;
      cyc(1'b0);
      rst_n = 1'b1;
      cyc(1'b0);
      chk("postrst.ready", 32'(load_ready), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule

// File: doc/photo_reader_emu.md
# photo_reader_emu

Emulates the built-in photoelectric tape reader behind connector PL6. It is the stage directly upstream of the G-15 top level: it drives the five photo-cell lines and the wait-for-tape signal into the machine, and consumes the machine's forward, reverse and remote-rewind relay commands. Tape images are loaded from a host-side byte interface into an internal frame buffer. The block plays them back at millisecond-tick-paced frame rates, tracking tape position in both directions.

## Interface
Parameters:
- DEPTH, 4096: frame buffer capacity in frames. Must be a power of two. Define AW = clog2(DEPTH).
- FRAME_MS, 4: tick_ms periods per frame in forward/reverse (250 frames/s).
- HOLD_MS, 2: ticks per frame during which the photo lines present data. Constraint: 1 ≤ HOLD_MS < FRAME_MS.
- START_MS, 20: motor start delay, in ticks, before the first frame.
- REWIND_MS, 1: ticks per frame while rewinding.

Ports:
- CLOCK  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_ms  in  1  one-CLOCK pulse every millisecond.
- PHOTO_TAPE_FWD  in  1  forward relay RY-A energized.
- PHOTO_TAPE_REV  in  1  reverse relay RY-B energized.
- REMOTE_REWIND  in  1  remote rewind request.
- PHOTO1..PHOTO5  out  1 each  photo-cell levels for the frame currently under the head.
- WAIT_FOR_TAPE  out  1  motor running.
- load_clear  in  1  empty the buffer. Honoured only in IDLE.
- load_valid  in  1  host frame valid.
- load_data  in  5  host frame. Bit 0 maps to PHOTO1.
- load_ready  out  1  buffer accepts a frame.
- tape_len  out  AW+1  frames loaded.
- tape_pos  out  AW+1  head position, in frames from the start of tape.
- at_end  out  1  head parked at a tape boundary in the commanded direction.

## Operation
Direction command is evaluated every CLOCK in this priority order:
1. REMOTE_REWIND → REW.
2. FWD and REV both asserted → STOP.
3. FWD → F.
4. REV → R.
5. Neither → STOP.

States:
- IDLE: photo lines 0; WAIT_FOR_TAPE 0.
  - Command F, R or REW → START, with the start counter cleared.
- START: counts START_MS ticks.
  - If the command changes during START, the counter restarts.
  - If the command becomes STOP → IDLE.
  - When the count completes → RUN_F, RUN_R or RUN_W, with phase = 0.
- RUN_F: presents buf[tape_pos] while phase < HOLD_MS, else 0.
  - phase increments on each tick; it wraps at FRAME_MS - 1 → 0.
  - On wrap, tape_pos increments.
  - Entered or reaching tape_pos == tape_len → END.
- RUN_R: same as RUN_F but presents buf[tape_pos-1].
  - On wrap, tape_pos decrements.
  - tape_pos == 0 → END.
- RUN_W: photo lines 0. tape_pos decrements every REWIND_MS ticks.
  - tape_pos == 0 → END.
- END: photo lines 0; at_end = 1; WAIT_FOR_TAPE stays 1.
  - Command changes to STOP → IDLE.
  - Command changes to another direction → START.

Rules that apply in any RUN state:
- A command change → STOP goes to IDLE; a change to another direction goes to START.
- A frame abandoned part-way does not move tape_pos.
- WAIT_FOR_TAPE = 1 in START, RUN_* and END.

Loading:
- load_ready = (state == IDLE) & (tape_len < DEPTH) & ~load_clear.
- When load_valid & load_ready: buf[tape_len] ← load_data and tape_len++.
- load_clear in IDLE sets tape_len = 0 and tape_pos = 0.
- Loading never moves tape_pos.

## Timing
- Reset values: PHOTO1..5 = 0, WAIT_FOR_TAPE = 0, load_ready = 0 during reset, tape_len = 0, tape_pos = 0, at_end = 0, state IDLE. Buffer contents are not reset.
- Reset asserted mid-operation forces all of the above asynchronously. After reset releases, load_ready rises on the next CLOCK.
- All outputs are registered. Each responds one CLOCK after the input change or tick that causes it.
- Buffer read latency is 1 CLOCK and is absorbed into the output register: photo data changes exactly one CLOCK after the qualifying tick.
- First forward frame: START_MS ticks after the command, PHOTO lines show buf[0] for HOLD_MS ticks, then 0 for FRAME_MS - HOLD_MS ticks.
- tape_pos and the next frame's data update on the same CLOCK.
- An empty tape (tape_len = 0) with command F goes START → END after START_MS ticks.
- tape_pos never exceeds tape_len and never goes below 0.
- Counters: phase is clog2(FRAME_MS) bits. The start counter is clog2(START_MS + 1) bits. No arithmetic wraps beyond these bounds.

## Test plan
- Load frames 0x01, 0x1F, 0x0A. Assert FWD with default parameters. Required response:
  - WAIT_FOR_TAPE = 1 after 1 CLOCK.
  - PHOTO = 0x01 at tick 20–21, 0x1F at tick 24–25, 0x0A at tick 28–29.
  - Then END with at_end = 1 and tape_pos = 3.
- From tape_pos = 3, swap FWD for REV. Required response: START again, then frames 0x0A, 0x1F, 0x01, ending at tape_pos = 0 with at_end = 1.
- At tape_pos = 2, assert REMOTE_REWIND together with FWD. Required response:
  - REW wins and photo lines stay 0.
  - After START, tape_pos reaches 0 within 2 ticks; END follows.
  - Dropping both inputs → IDLE and WAIT_FOR_TAPE = 0.
- Assert FWD and REV simultaneously. Required response: stays IDLE, WAIT_FOR_TAPE = 0, PHOTO = 0.
- Drop FWD at phase 1 of frame 1. Required response: IDLE on the next CLOCK, tape_pos = 1, PHOTO = 0.
- Fill DEPTH frames. Required response: load_ready falls after the last write. load_clear then gives tape_len = 0 and load_ready = 1. Asserting rst_n low mid-RUN_F zeroes all outputs immediately.
